// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and types for the memory-mapped UART receiver.
//   - Default register addresses for RXD and CON.
//   - Bit positions inside the CON register.
//   - Receiver FSM state encoding.
package uart_pkg;

    localparam logic [31:0] RXD_ADDR_DEFAULT = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR_DEFAULT = 32'h4000_0020;

    localparam int unsigned CON_IRQ_EN = 0;
    localparam int unsigned CON_VALID  = 3;
    localparam int unsigned CON_OVR    = 4;
    localparam int unsigned CON_FERR   = 5;
    localparam int unsigned CON_BUSY   = 6;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 deserialiser.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   rx          - serial input, idle high, asynchronous to clk
//   byte_done   - one-cycle pulse at a good stop-bit sample; rx_byte is valid with it
//   rx_byte     - assembled byte (LSB received first)
//   frame_err   - one-cycle pulse when the stop bit samples low
//   busy        - high whenever the FSM is not idle
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10417
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_done,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned BC_W = $clog2(BAUD_DIV);
    localparam logic [BC_W-1:0] BC_HALF = BC_W'(BAUD_DIV / 2 - 1);
    localparam logic [BC_W-1:0] BC_FULL = BC_W'(BAUD_DIV - 1);

    logic            rx_meta_q;
    logic            rxs_q;
    rx_state_e       state_q, state_d;
    logic [BC_W-1:0] bc_q, bc_d;
    logic [2:0]      bi_q, bi_d;
    logic [7:0]      shreg_q, shreg_d;

    // Synchroniser resets high so a reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StIdle;
            bc_q      <= '0;
            bi_q      <= '0;
            shreg_q   <= '0;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            bc_q      <= bc_d;
            bi_q      <= bi_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bc_d      = bc_q;
        bi_d      = bi_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    bc_d    = '0;
                end
            end
            StStart: begin
                // Half-bit wait puts every later sample near the bit centre.
                if (bc_q == BC_HALF) begin
                    bc_d = '0;
                    if (rxs_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        bi_d    = '0;
                    end
                end else begin
                    bc_d = bc_q + BC_W'(1);
                end
            end
            StData: begin
                if (bc_q == BC_FULL) begin
                    bc_d    = '0;
                    shreg_d = {rxs_q, shreg_q[7:1]};
                    bi_d    = bi_q + 3'd1;
                    if (bi_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    bc_d = bc_q + BC_W'(1);
                end
            end
            StStop: begin
                if (bc_q == BC_FULL) begin
                    bc_d    = '0;
                    state_d = StIdle;
                    if (rxs_q) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    bc_d = bc_q + BC_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rx_byte = shreg_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: memory-mapped UART receiver with level interrupt.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   rx           - serial input
//   Address      - byte address, decoded on Address[31:2]
//   MemRead      - read strobe; Read_data answers on the following cycle
//   MemWrite     - write strobe
//   Write_data   - store data; only bit 0 is used (CON.irq_en)
//   Read_data    - registered read data, 0 when not selected
//   rx_ecp       - interrupt request, irq_en & rx_valid
//   rx_busy      - a frame is in progress
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 10417,
    parameter logic [31:0] RXD_ADDR = RXD_ADDR_DEFAULT,
    parameter logic [31:0] CON_ADDR = CON_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic [31:0] Address,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        rx_ecp,
    output logic        rx_busy
);

    logic       byte_done;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       busy;

    uart_rx_core #(
        .BAUD_DIV (BAUD_DIV)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_done (byte_done),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .busy      (busy)
    );

    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        ferr_q, ferr_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] read_data_q, read_data_d;

    logic        rd_rxd, rd_con, wr_con;
    logic [31:0] con_value;

    logic unused_bits;
    assign unused_bits = ^{Address[1:0], Write_data[31:1]};

    assign rd_rxd = MemRead  && (Address[31:2] == RXD_ADDR[31:2]);
    assign rd_con = MemRead  && (Address[31:2] == CON_ADDR[31:2]);
    assign wr_con = MemWrite && (Address[31:2] == CON_ADDR[31:2]);

    always_comb begin
        con_value             = '0;
        con_value[CON_IRQ_EN] = irq_en_q;
        con_value[CON_VALID]  = rx_valid_q;
        con_value[CON_OVR]    = overrun_q;
        con_value[CON_FERR]   = ferr_q;
        con_value[CON_BUSY]   = busy;
    end

    always_comb begin
        read_data_d = '0;
        if (rd_rxd) begin
            read_data_d = {24'b0, rx_data_q};
        end else if (rd_con) begin
            read_data_d = con_value;
        end

        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        if (byte_done) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
        end else if (rd_rxd) begin
            rx_valid_d = 1'b0;
        end

        // A byte landing while an RXD read consumes the old one is not an overrun.
        overrun_d = overrun_q;
        if (rd_con) begin
            overrun_d = 1'b0;
        end
        if (byte_done && rx_valid_q && !rd_rxd) begin
            overrun_d = 1'b1;
        end

        // Set wins over the read-clear.
        ferr_d = ferr_q;
        if (rd_con) begin
            ferr_d = 1'b0;
        end
        if (frame_err) begin
            ferr_d = 1'b1;
        end

        irq_en_d = irq_en_q;
        if (wr_con) begin
            irq_en_d = Write_data[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            ferr_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            ferr_q      <= ferr_d;
            irq_en_q    <= irq_en_d;
            read_data_q <= read_data_d;
        end
    end

    assign Read_data = read_data_q;
    assign rx_ecp    = irq_en_q & rx_valid_q;
    assign rx_busy   = busy;

endmodule

// File: doc/uart_rx_mmio.md
Name: uart_rx_mmio

Overview:
Memory-mapped UART receiver peripheral on the CPU data bus. It is the source of the rx exception that the pipelined core consumes.
- Deserialises 8N1 frames from the `rx` pin and holds the last byte.
- Exposes the byte and status through two word registers.
- Drives a level interrupt, `rx_ecp`, that the core's exception logic vectors to 0x8000_0008.
- Sits beside the data memory and its read mux; its `Read_data` is OR-combined with the other peripherals.

Parameters:
- BAUD_DIV, 10417, clock cycles per bit (100 MHz / 9600). Must be >= 4.
- RXD_ADDR, 32'h4000_001C, address of the received-data register.
- CON_ADDR, 32'h4000_0020, address of the control/status register.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- rx  in  1  serial input; idle high; asynchronous to clk
- Address  in  32  byte address from the EX stage; decoded on Address[31:2]
- MemRead  in  1  read strobe, EX stage
- MemWrite  in  1  write strobe, EX stage
- Write_data  in  32  store data
- Read_data  out  32  registered read data; 0 when not selected
- rx_ecp  out  1  interrupt request = irq_en & rx_valid
- rx_busy  out  1  high while a frame is being received (state != IDLE)

Behaviour:
Reset: clk is the clock; reset is asynchronous and active-high. On reset:
- Both sync flops go to 1.
- State goes to IDLE; bit counter and baud counter go to 0.
- rx_data, rx_valid, overrun, ferr, irq_en and Read_data go to 0, so rx_ecp=0 and rx_busy=0.
- A reset in the middle of a frame aborts it. The remaining low bits of that frame may start a new (glitch-checked) frame.

Synchroniser: two flops; all FSM logic uses the second flop (rxs).

FSM, with baud counter bc and bit index bi:
- IDLE: when rxs==0, go to START with bc=0.
- START: when bc==BAUD_DIV/2-1 (integer divide), sample rxs.
  - rxs==0: go to DATA with bc=0, bi=0.
  - rxs==1 (glitch): go to IDLE; nothing is recorded.
- DATA: when bc==BAUD_DIV-1, shift rxs into shreg LSB-first, set bc=0, bi++. After bi==7 is sampled, go to STOP.
- STOP: when bc==BAUD_DIV-1, sample rxs and go to IDLE.
  - rxs==1: rx_data<=shreg and rx_valid<=1. If rx_valid was already 1 and is not being cleared in this same cycle, overrun<=1.
  - rxs==0: ferr<=1; rx_data and rx_valid are unchanged.
- Every sample point is at the bit centre, ±1 cycle.

Bus timing:
- The address and strobes are sampled at a clock edge. Read_data is valid the following cycle, which matches the core's MEM stage.
- Side effects of a read take place at that same sampling edge.

Registers:
- RXD, read: {24'b0, rx_data}. The read clears rx_valid. Writes are ignored.
- CON, read: {25'b0, busy[6], ferr[5], overrun[4], rx_valid[3], 2'b0, irq_en[0]}. The read clears ferr and overrun.
- CON, write: irq_en<=Write_data[0]; all other bits are ignored.
- Any read of an unmatched address returns 0. When MemRead=0, the next-cycle Read_data is 0.

Simultaneous events:
- Frame completion in the same cycle as an RXD read: the read returns the old byte. The new byte is latched and rx_valid stays 1; no overrun is flagged.
- Framing error in the same cycle as a CON read: the read returns the old ferr. ferr ends at 1 (set wins over clear).
- MemRead and MemWrite both high on CON: the read returns the pre-write irq_en value, and the write still takes effect.

rx_ecp: combinational from registers, with no pulse stretching. It drops the cycle after the RXD-read edge.

Decomposition:
- Package uart_pkg:
  - RXD_ADDR and CON_ADDR defaults.
  - CON bit-position constants (IRQ_EN=0, VALID=3, OVR=4, FERR=5, BUSY=6).
  - Rx state enum {IDLE, START, DATA, STOP}.
- One sub-module, uart_rx_core, owns the sync flops, the FSM, the counters and shreg.
  - Outputs: byte_done pulse, byte, frame_err pulse, busy.
  - The top level holds the register file, bus decode and interrupt.

Test Plan:
All scenarios use BAUD_DIV=16.
1. Good byte: irq_en=1, send 0xA5 → rx_valid=1 and rx_ecp=1 about 152 cycles after the start edge. An RXD read returns 0x0000_00A5 on the next cycle, and rx_ecp=0 one cycle after the read edge.
2. Glitch: rx low for 3 cycles, then high → state returns to IDLE; rx_valid=0 and rx_busy drops. The following 0x3C frame is received correctly.
3. Framing error: send 0x55 with stop bit 0 → CON reads 0x20 (ferr only). A second CON read returns 0x00; RXD is unchanged.
4. Overrun: send 0x11 then 0x22 without reading → RXD=0x22; CON=0x18 (overrun and valid). After a CON read, CON=0x08.
5. Reset mid-frame: assert reset during bit 3 → all outputs are 0 while reset is held. A fresh 0x7E frame after release is received.
6. Collision: time an RXD read to the exact STOP-sample cycle of 0x99 while 0x42 is held → the read returns 0x42; afterwards RXD=0x99, rx_valid=1, overrun=0.
